// File: rtl/helloworld_vector_sequencer_pkg.sv
// Shared definitions for the HelloWorld vector sequencer: FSM state
// encoding, default sizes, signature seed and the dut_out bit order.
package helloworld_seq_pkg;

  localparam int OUT_W_DEF   = 16;
  localparam int NUM_VEC_DEF = 16;

  // The signature register starts every run from this value.
  localparam logic [15:0] SIG_SEED = 16'h0000;

  // dut_out bit order: netlist output z0re sits at bit 0 and the remaining
  // outputs follow in the fixed netlist order up to bit OUT_W-1.
  localparam int DUT_OUT_Z0RE_BIT = 0;

  // drv_x bit order: bit 2 drives x25, bit 1 drives x24, bit 0 drives x23.
  localparam int DRV_X25_BIT = 2;
  localparam int DRV_X24_BIT = 1;
  localparam int DRV_X23_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/helloworld_vector_sequencer_if.sv
// Pad-level bus between the sequencer and the HelloWorld netlist.
// Signalling: there is no valid/ready handshake on this bus. The master
// holds drv_test/drv_x steady for a whole vector; the slave (the netlist)
// presents dut_out combinationally and the master samples it in CAPTURE.
interface helloworld_vector_sequencer_if #(
  parameter int OUT_W = 16
);
  logic             drv_test;
  logic [2:0]       drv_x;
  logic [OUT_W-1:0] dut_out;

  modport master (output drv_test, output drv_x, input dut_out);
  modport slave  (input drv_test, input drv_x, output dut_out);
endinterface

// File: rtl/helloworld_sig_accum.sv
// Rotate-XOR signature register with clear, enable and compare output.
module helloworld_sig_accum
  import helloworld_seq_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  input  logic [OUT_W-1:0] exp_sig,
  output logic [OUT_W-1:0] sig,
  output logic             match
);

  // Fold one capture per enable: rotate left by one, then XOR the sample.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= OUT_W'(SIG_SEED);
    end else if (en) begin
      sig <= {sig[OUT_W-2:0], sig[OUT_W-1]} ^ din;
    end
  end

  // Compare against the expected signature.
  always_comb begin
    match = (sig == exp_sig);
  end

endmodule

// File: rtl/helloworld_vector_sequencer.sv
// Steps the HelloWorld netlist inputs through all vectors, waits a settle
// time per vector, folds the outputs into a signature and reports pass/fail.
module helloworld_vector_sequencer
  import helloworld_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int NUM_VEC       = NUM_VEC_DEF
) (
  input  logic                          bertaClock,
  input  logic                          global_reset,
  input  logic                          start,
  input  logic [OUT_W-1:0]              exp_sig,
  helloworld_vector_sequencer_if.master pads,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [OUT_W-1:0]              signature,
  output logic [3:0]                    vec_idx,
  output seq_state_t                    dbg_state
);

  localparam logic [3:0] LAST_VEC    = 4'(NUM_VEC - 1);
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic [3:0] vec_q;
  logic [7:0] cnt_q;
  logic       pass_q;
  logic       sig_clr;
  logic       sig_en;
  logic       sig_match;

  // State register.
  always_ff @(posedge bertaClock) begin
    if (global_reset) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic plus signature clear/enable strobes.
  always_comb begin
    state_d = state_q;
    sig_clr = 1'b0;
    sig_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          sig_clr = 1'b1;
        end
      end
      ST_APPLY: begin
        state_d = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        sig_en  = 1'b1;
        state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Vector index, settle counter and the held pass result.
  always_ff @(posedge bertaClock) begin
    if (global_reset) begin
      vec_q  <= 4'd0;
      cnt_q  <= 8'd0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q  <= 4'd0;
            pass_q <= 1'b0;
          end
        end
        ST_APPLY: begin
          cnt_q <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        end
        ST_CAPTURE: begin
          if (vec_q != LAST_VEC) vec_q <= vec_q + 4'd1;
        end
        ST_DONE: begin
          pass_q <= sig_match;
        end
        default: begin
          cnt_q <= 8'd0;
        end
      endcase
    end
  end

  helloworld_sig_accum #(.OUT_W(OUT_W)) u_sig_accum (
    .clk     (bertaClock),
    .rst     (global_reset),
    .clr     (sig_clr),
    .en      (sig_en),
    .din     (pads.dut_out),
    .exp_sig (exp_sig),
    .sig     (signature),
    .match   (sig_match)
  );

  // Status outputs and pad drivers. The drivers follow vec_idx only while a
  // vector is active, so they change solely on entry to APPLY and are zero
  // in IDLE and DONE.
  always_comb begin
    busy          = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    done          = (state_q == ST_DONE);
    pass          = pass_q;
    vec_idx       = vec_q;
    dbg_state     = state_q;
    pads.drv_test = busy ? vec_q[3] : 1'b0;
    pads.drv_x    = busy ? {vec_q[DRV_X25_BIT], vec_q[DRV_X24_BIT], vec_q[DRV_X23_BIT]} : 3'b000;
  end

endmodule

// File: tb/tb_helloworld_vector_sequencer.sv
// Directed bench for the HelloWorld vector sequencer: a stand-in netlist
// maps the pad drivers to outputs, and each run's expected signature is
// queued at start and checked when done pulses.
module tb_helloworld_vector_sequencer;
  import helloworld_seq_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start4 = 1'b0;
  logic         start0 = 1'b0;
  logic [W-1:0] exp_sig = '0;
  int           mode = 0;
  logic         sel = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  logic         busy4, done4, pass4, busy0, done0, pass0;
  logic [W-1:0] sig4, sig0;
  logic [3:0]   vec4, vec0;
  seq_state_t   st4, st0;

  helloworld_vector_sequencer_if #(.OUT_W(W)) if4 ();
  helloworld_vector_sequencer_if #(.OUT_W(W)) if0 ();

  helloworld_vector_sequencer #(.SETTLE_CYCLES(4), .OUT_W(W), .NUM_VEC(16)) dut4 (
    .bertaClock(clk), .global_reset(rst), .start(start4), .exp_sig(exp_sig),
    .pads(if4.master), .busy(busy4), .done(done4), .pass(pass4),
    .signature(sig4), .vec_idx(vec4), .dbg_state(st4)
  );

  helloworld_vector_sequencer #(.SETTLE_CYCLES(0), .OUT_W(W), .NUM_VEC(16)) dut0 (
    .bertaClock(clk), .global_reset(rst), .start(start0), .exp_sig(exp_sig),
    .pads(if0.master), .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0), .vec_idx(vec0), .dbg_state(st0)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Stand-in netlist: output pattern chosen by mode, indexed by the pads.
  function automatic logic [W-1:0] pattern(input int m, input logic [3:0] v);
    logic [W-1:0] p;
    if (m == 0)      p = '0;
    else if (m == 1) p = 16'h0001;
    else             p = {v, 4'h0, ~v, 4'h3} ^ (16'h0001 << v);
    return p;
  endfunction

  function automatic logic [W-1:0] model_sig(input int m);
    logic [W-1:0] s;
    s = SIG_SEED;
    for (int v = 0; v < 16; v++) s = {s[W-2:0], s[W-1]} ^ pattern(m, 4'(v));
    return s;
  endfunction

  always_comb begin
    if4.dut_out = pattern(mode, {if4.drv_test, if4.drv_x});
    if0.dut_out = pattern(mode, {if0.drv_test, if0.drv_x});
  end

  // Observation mux over the two builds.
  logic         busy_m, done_m, pass_m, drv_t_m;
  logic [2:0]   drv_x_m;
  logic [W-1:0] sig_m;
  seq_state_t   st_m;
  always_comb begin
    busy_m  = sel ? busy0 : busy4;
    done_m  = sel ? done0 : done4;
    pass_m  = sel ? pass0 : pass4;
    sig_m   = sel ? sig0 : sig4;
    st_m    = sel ? st0 : st4;
    drv_t_m = sel ? if0.drv_test : if4.drv_test;
    drv_x_m = sel ? if0.drv_x : if4.drv_x;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full run on the selected build, checked cycle by cycle.
  task automatic do_run(input bit s0, input int mode_i, input logic [W-1:0] exp_i, input bit repulse);
    int period;
    int done_at;
    int done_cnt;
    logic [W-1:0] sig_exp;
    logic [W-1:0] popped;
    period   = s0 ? 2 : 6;
    done_at  = 1 + 16 * period;
    done_cnt = 0;
    sig_exp  = model_sig(mode_i);
    mode     = mode_i;
    exp_sig  = exp_i;
    sel      = s0;
    @(negedge clk);
    check("idle_before_start", {31'd0, busy_m}, 32'd0);
    exp_q.push_back(sig_exp);
    if (s0) start0 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start4 = 1'b0;
    for (int c = 1; c <= done_at + 3; c++) begin
      if (c == 1) begin
        check("sig_cleared", 32'(sig_m), 32'd0);
        check("pass_cleared", {31'd0, pass_m}, 32'd0);
      end
      if (c < done_at) begin
        check("drivers", {28'd0, drv_t_m, drv_x_m}, 32'((c - 1) / period));
        check("busy_run", {31'd0, busy_m}, 32'd1);
      end else begin
        check("drivers_zero", {28'd0, drv_t_m, drv_x_m}, 32'd0);
        check("busy_low", {31'd0, busy_m}, 32'd0);
      end
      if (done_m) begin
        done_cnt++;
        check("done_cycle", 32'(c), 32'(done_at));
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd1, 32'd0);
        end else begin
          popped = exp_q.pop_front();
          check("signature", 32'(sig_m), 32'(popped));
        end
      end
      if (c > done_at) begin
        check("back_idle", 32'(st_m), 32'(ST_IDLE));
        check("pass", {31'd0, pass_m}, {31'd0, sig_exp == exp_i});
        check("sig_held", 32'(sig_m), 32'(sig_exp));
      end
      if (repulse && (c == 10 || c == done_at)) begin
        if (s0) start0 = 1'b1; else start4 = 1'b1;
      end else begin
        start0 = 1'b0;
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    // Reset with start also high: reset wins.
    start4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(st4), 32'(ST_IDLE));
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_pass", {31'd0, pass4}, 32'd0);
    check("rst_sig", 32'(sig4), 32'd0);
    check("rst_vec", 32'(vec4), 32'd0);
    check("rst_drv", {28'd0, if4.drv_test, if4.drv_x}, 32'd0);
    start4 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(st4), 32'(ST_IDLE));

    do_run(1'b0, 0, 16'h0000, 1'b0);
    do_run(1'b0, 1, 16'hFFFF, 1'b0);
    do_run(1'b0, 1, 16'hFFFE, 1'b0);
    do_run(1'b0, 2, model_sig(2), 1'b1);
    do_run(1'b0, 2, 16'h1234, 1'b1);
    do_run(1'b1, 2, model_sig(2), 1'b0);
    do_run(1'b1, 1, 16'hFFFE, 1'b0);

    // Reset in the middle of a run.
    sel = 1'b0;
    mode = 2;
    exp_sig = model_sig(2);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (39) @(negedge clk);
    check("mid_busy_before", {31'd0, busy4}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_state", 32'(st4), 32'(ST_IDLE));
    check("mid_rst_busy", {31'd0, busy4}, 32'd0);
    check("mid_rst_sig", 32'(sig4), 32'd0);
    check("mid_rst_drv", {28'd0, if4.drv_test, if4.drv_x}, 32'd0);
    check("mid_rst_done", {31'd0, done4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", {31'd0, done4}, 32'd0);
    end
    do_run(1'b0, 2, model_sig(2), 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
